// File: rtl/alu_exec_pkg.sv
// Shared definitions for the multicycle ALU execute stage: the op codes driven by
// ALU control, the 2-bit FSM state encoding, and the per-edge step of the fast shifter.
package alu_exec_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_LUI = 4'b1001;

  // Bits shifted per SHIFT edge when ALU_FAST_SHIFT_EN is defined.
  localparam int unsigned FAST_STEP = 4;

  // One-hot-ish encoding so busy and done decode to a single state bit each.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-step shifter used by the iterative shift datapath.
// Ports:
//   data_i  operand being shifted
//   dir_i   0 = shift left, 1 = logical shift right
//   amt_i   bits to shift this step
//   data_o  shifted value, zero filled
module alu_shift_step #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic                   dir_i,
  input  logic [SHAMT_WIDTH-1:0] amt_i,
  output logic [DATA_WIDTH-1:0]  data_o
);

  always_comb begin
    data_o = dir_i ? (data_i >> amt_i) : (data_i << amt_i);
  end

endmodule

// File: rtl/alu_multicycle_exec.sv
// Multicycle ALU execute stage. Logic/arithmetic ops complete in one cycle; SLL/SRL
// iterate over a narrow shifter under a start/busy/done handshake. The result and
// Zero flag are registered and only change on entry to DONE.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   start_i           request, accepted only while ready_o is high
//   ALU_Operation_i   4-bit op code (see alu_exec_pkg)
//   A_i, B_i          operands, sampled on the accept edge; shamt = B_i[SHAMT_WIDTH-1:0]
//   ready_o           high in IDLE or DONE
//   busy_o            high in SHIFT
//   done_o            one-cycle result-valid pulse
//   ALU_Result_o      registered result
//   Zero_o            registered (ALU_Result_o == 0)
// Configuration macro: ALU_FAST_SHIFT_EN -- shift up to FAST_STEP bits per edge
// instead of one.
module alu_multicycle_exec
  import alu_exec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o
);

  alu_state_e              state_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    zero_q;
  logic [DATA_WIDTH-1:0]   work_q;
  logic [SHAMT_WIDTH-1:0]  cnt_q;
  logic                    dir_q;

  logic [SHAMT_WIDTH-1:0]  shamt;
  logic                    is_shift;
  logic [DATA_WIDTH-1:0]   single_res;
  logic [SHAMT_WIDTH-1:0]  step_amt;
  logic [DATA_WIDTH-1:0]   shift_out;

  assign shamt    = B_i[SHAMT_WIDTH-1:0];
  assign is_shift = (ALU_Operation_i == ALU_SLL) || (ALU_Operation_i == ALU_SRL);

  // Result for everything that finishes on the accept edge.
  always_comb begin
    single_res = '0;
    case (ALU_Operation_i)
      ALU_ADD: single_res = A_i + B_i;
      ALU_SUB: single_res = A_i - B_i;
      ALU_AND: single_res = A_i & B_i;
      ALU_OR:  single_res = A_i | B_i;
      ALU_XOR: single_res = A_i ^ B_i;
      // Only reached with shamt == 0, so the shift is the identity.
      ALU_SLL: single_res = A_i;
      ALU_SRL: single_res = A_i;
      ALU_LUI: single_res = B_i;
      default: single_res = '0;
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN
  localparam logic [SHAMT_WIDTH-1:0] StepMax = SHAMT_WIDTH'(FAST_STEP);

  always_comb begin
    step_amt = (cnt_q > StepMax) ? StepMax : cnt_q;
  end
`else
  always_comb begin
    step_amt = SHAMT_WIDTH'(1);
  end
`endif

  alu_shift_step #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shift_step (
    .data_i (work_q),
    .dir_i  (dir_q),
    .amt_i  (step_amt),
    .data_o (shift_out)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b0;
      work_q   <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            if (is_shift && (shamt != '0)) begin
              work_q  <= A_i;
              cnt_q   <= shamt;
              dir_q   <= (ALU_Operation_i == ALU_SRL);
              state_q <= StShift;
            end else begin
              result_q <= single_res;
              zero_q   <= (single_res == '0);
              state_q  <= StDone;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          // start_i is deliberately ignored here; requests are not queued.
          work_q <= shift_out;
          cnt_q  <= cnt_q - step_amt;
          if (cnt_q == step_amt) begin
            result_q <= shift_out;
            zero_q   <= (shift_out == '0);
            state_q  <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode straight from the state register, so they are glitch-free.
  assign busy_o       = (state_q == StShift);
  assign done_o       = (state_q == StDone);
  assign ready_o      = (state_q != StShift);
  assign ALU_Result_o = result_q;
  assign Zero_o       = zero_q;

endmodule

// File: tb/tb_alu_multicycle_exec.sv
module tb_alu_multicycle_exec;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        zero_o;

  int checks = 0;
  int errors = 0;

`ifdef ALU_FAST_SHIFT_EN
  localparam int SllLat  = 9;
  localparam int SllBusy = 8;
  localparam int SrlLat  = 2;
`else
  localparam int SllLat  = 32;
  localparam int SllBusy = 31;
  localparam int SrlLat  = 5;
`endif

  alu_multicycle_exec #(
    .DATA_WIDTH  (32),
    .SHAMT_WIDTH (5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .ALU_Operation_i (op),
    .A_i             (a),
    .B_i             (b),
    .ready_o         (ready_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .ALU_Result_o    (result_o),
    .Zero_o          (zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge; returns sampled #1 after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
    op      = o;
    a       = av;
    b       = bv;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Called right after issue(); lat is 1 at that point. Bounded wait for done_o.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = 0;
    while (!done_o && lat < 64) begin
      if (busy_o) busy_cnt++;
      step();
      lat++;
    end
  endtask

  int lat;
  int bcnt;
  int dcnt;

  initial begin
    reset   = 1'b0;
    start_i = 1'b1;
    op      = 4'b0000;
    a       = 32'd5;
    b       = 32'd3;
    step();
    step();
    reset   = 1'b1;
    start_i = 1'b0;
    // start_i during reset must have been ignored
    check_eq("rst_ready", 32'(ready_o), 32'd1);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_result", result_o, 32'h0);
    check_eq("rst_zero", 32'(zero_o), 32'd0);

    // ADD
    issue(4'b0000, 32'h0000_0005, 32'h0000_0003);
    check_eq("add_done", 32'(done_o), 32'd1);
    check_eq("add_result", result_o, 32'h8);
    check_eq("add_zero", 32'(zero_o), 32'd0);
    step();
    check_eq("add_done_pulse", 32'(done_o), 32'd0);
    check_eq("add_hold", result_o, 32'h8);

    // SUB to zero
    issue(4'b0001, 32'h1234_5678, 32'h1234_5678);
    check_eq("sub_done", 32'(done_o), 32'd1);
    check_eq("sub_result", result_o, 32'h0);
    check_eq("sub_zero", 32'(zero_o), 32'd1);
    step();

    // SLL by 31
    issue(4'b0110, 32'h0000_0001, 32'd31);
    check_eq("sll_ready_low", 32'(ready_o), 32'd0);
    check_eq("sll_result_held", result_o, 32'h0);
    wait_done(lat, bcnt);
    check_eq("sll_latency", 32'(lat), 32'(SllLat));
    check_eq("sll_busy_cycles", 32'(bcnt), 32'(SllBusy));
    check_eq("sll_result", result_o, 32'h8000_0000);
    check_eq("sll_zero", 32'(zero_o), 32'd0);
    step();

    // SRL shamt 4 (upper bits of B ignored), start_i held during SHIFT
    issue(4'b0111, 32'h8000_0000, 32'h0000_0024);
    check_eq("srl_busy", 32'(busy_o), 32'd1);
    check_eq("srl_result_held", result_o, 32'h8000_0000);
    op      = 4'b0000;
    a       = 32'd1;
    b       = 32'd1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    lat = 2;
    while (!done_o && lat < 64) begin
      step();
      lat++;
    end
    check_eq("srl_latency", 32'(lat), 32'(SrlLat));
    check_eq("srl_result", result_o, 32'h0800_0000);
    step();
    check_eq("srl_no_requeue", 32'(done_o), 32'd0);
    check_eq("srl_hold", result_o, 32'h0800_0000);

    // Back-to-back: AND then XOR issued during DONE
    issue(4'b0010, 32'h0000_F0F0, 32'h0000_FF00);
    check_eq("and_result", result_o, 32'h0000_F000);
    issue(4'b0100, 32'h0000_00FF, 32'h0000_000F);
    check_eq("b2b_done", 32'(done_o), 32'd1);
    check_eq("xor_result", result_o, 32'h0000_00F0);
    step();

    // OR, SLL with shamt 0 (one-cycle), LUI
    issue(4'b0011, 32'h0000_00F0, 32'h0000_0F00);
    check_eq("or_result", result_o, 32'h0000_0FF0);
    step();
    issue(4'b0110, 32'h0000_1234, 32'h0000_0020);
    check_eq("sll0_done", 32'(done_o), 32'd1);
    check_eq("sll0_result", result_o, 32'h0000_1234);
    step();
    issue(4'b1001, 32'h1111_1111, 32'hABCD_E000);
    check_eq("lui_result", result_o, 32'hABCD_E000);
    step();

    // Reset during SLL shamt 10 aborts the op
    issue(4'b0110, 32'h0000_0001, 32'd10);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_eq("abort_ready", 32'(ready_o), 32'd1);
    check_eq("abort_busy", 32'(busy_o), 32'd0);
    check_eq("abort_result", result_o, 32'h0);
    check_eq("abort_zero", 32'(zero_o), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_o) dcnt++;
      step();
    end
    check_eq("abort_no_done", 32'(dcnt), 32'd0);

    // Unknown op code
    issue(4'b1111, 32'hFFFF_FFFF, 32'h0000_0001);
    check_eq("unk_done", 32'(done_o), 32'd1);
    check_eq("unk_result", result_o, 32'h0);
    check_eq("unk_zero", 32'(zero_o), 32'd1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
